// File: rtl/counter_bcd_chain.sv
// Multi-digit BCD up/down counter with clear, load, cascade tc and sticky ovf; COUNTER_BCD_SATURATE_EN selects saturation.
// Latency one clk from clr/load/en to cnt; tc is combinational; no backpressure (steps whenever en is high).
module counter_bcd_chain #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   cnt,
   output logic                  tc,
   output logic                  ovf
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] cnt_q;
   logic [W-1:0] step_val;
   logic [W-1:0] load_bcd;
   logic         all9;
   logic         all0;
   logic         at_limit;
   logic         ovf_q;

   // all9/all0 hold the "every lower digit is 9/0" carry while the loop runs,
   // and the whole-count condition once it finishes.
   always_comb begin
      step_val = cnt_q;
      load_bcd = '0;
      all9     = 1'b1;
      all0     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (up_dn && all9) begin
            step_val[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
         end
         if (!up_dn && all0) begin
            step_val[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd0) ? 4'd9 : cnt_q[4*i +: 4] - 4'd1;
         end
         load_bcd[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
         all9 = all9 & (cnt_q[4*i +: 4] == 4'd9);
         all0 = all0 & (cnt_q[4*i +: 4] == 4'd0);
      end
   end

   assign at_limit = up_dn ? all9 : all0;
   assign tc       = en & at_limit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clr) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (load) begin
         cnt_q <= load_bcd;
         ovf_q <= 1'b0;
      end else if (en) begin
`ifdef COUNTER_BCD_SATURATE_EN
         if (at_limit) begin
            ovf_q <= 1'b1;
         end else begin
            cnt_q <= step_val;
         end
`else
         cnt_q <= step_val;
         if (at_limit) begin
            ovf_q <= 1'b1;
         end
`endif
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_bcd_chain.sv
// Bench for counter_bcd_chain: directed cases plus randomized traffic against an integer-valued model.
module tb_counter_bcd_chain;

   localparam int D = 2;
   localparam int M = 100;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
   logic [7:0]   load_val = 8'h00;
   logic [7:0]   cnt;
   logic         tc, ovf;

   logic         c_en = 1'b0, c_clr = 1'b0;
   logic [3:0]   lo_cnt, hi_cnt;
   logic         lo_tc, hi_tc, lo_ovf, hi_ovf;

   int n_chk  = 0;
   int n_pass = 0;

   int m_n   = 0;
   bit m_ovf = 1'b0;

   always #5 clk = ~clk;

   counter_bcd_chain #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .cnt(cnt), .tc(tc), .ovf(ovf)
   );

   counter_bcd_chain #(.DIGITS(1)) u_lo (
      .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
      .load_val(4'h0), .cnt(lo_cnt), .tc(lo_tc), .ovf(lo_ovf)
   );

   counter_bcd_chain #(.DIGITS(1)) u_hi (
      .clk(clk), .rst(rst), .en(lo_tc), .up_dn(1'b1), .clr(c_clr), .load(1'b0),
      .load_val(4'h0), .cnt(hi_cnt), .tc(hi_tc), .ovf(hi_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask

   function automatic int bcd_to_int(input logic [7:0] v);
      int r = 0;
      logic [3:0] d;
      for (int i = D - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         r = r * 10 + ((d > 4'd9) ? 0 : int'(d));
      end
      return r;
   endfunction

   function automatic logic [7:0] int_to_bcd(input int n);
      logic [7:0] r = '0;
      int v = n;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Next-state of the decimal model from the inputs about to be sampled.
   task automatic model_apply();
      if (clr) begin
         m_n = 0; m_ovf = 1'b0;
      end else if (load) begin
         m_n = bcd_to_int(load_val); m_ovf = 1'b0;
      end else if (en) begin
         if ((up_dn && m_n == M - 1) || (!up_dn && m_n == 0)) begin
            m_ovf = 1'b1;
`ifndef COUNTER_BCD_SATURATE_EN
            m_n = up_dn ? 0 : M - 1;
`endif
         end else begin
            m_n = up_dn ? m_n + 1 : m_n - 1;
         end
      end
   endtask

   task automatic tick(input string tag);
      model_apply();
      @(posedge clk);
      #1;
      chk({tag, ".cnt"}, cnt, int_to_bcd(m_n));
      chk({tag, ".ovf"}, ovf, m_ovf);
   endtask

   task automatic drive(input logic c, input logic l, input logic [7:0] lv,
                        input logic e, input logic u);
      clr = c; load = l; load_val = lv; en = e; up_dn = u;
   endtask

   task automatic chk_tc(input string tag);
      bit exp_tc;
      #1;
      exp_tc = en && (up_dn ? (m_n == M - 1) : (m_n == 0));
      chk(tag, tc, exp_tc);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst.cnt", cnt, 8'h00);
      chk("rst.ovf", ovf, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Count up 12 steps from zero
      drive(0, 0, 8'h00, 1, 1);
      for (int i = 0; i < 12; i++) tick("up12");
      chk("up12.lit", cnt, 8'h12);
      chk("up12.ovf0", ovf, 1'b0);

      // Asynchronous reset mid-count, no clock edge needed
      tick("up13");
      #2;
      rst = 1'b0;
      #1;
      chk("arst.cnt", cnt, 8'h00);
      chk("arst.ovf", ovf, 1'b0);
      m_n = 0; m_ovf = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      drive(0, 0, 8'h00, 0, 1);
      tick("hold");

      // Up wrap from 98
      drive(0, 1, 8'h98, 1, 1);
      tick("ld98");
      drive(0, 0, 8'h00, 1, 1);
      tick("up99");
      chk_tc("up99.tc");
      tick("upwrap");
      chk_tc("upwrap.tc");

      // Down wrap from 01, then 10 more steps
      drive(0, 1, 8'h01, 1, 0);
      tick("ld01");
      drive(0, 0, 8'h00, 1, 0);
      tick("dn00");
      chk_tc("dn00.tc");
      tick("dnwrap");
      for (int i = 0; i < 10; i++) tick("dn10");

      // Priority: clr over load over en
      drive(1, 1, 8'h55, 1, 1);
      tick("pri.clr");
      chk("pri.clr.lit", cnt, 8'h00);
      drive(0, 1, 8'h55, 1, 1);
      tick("pri.ld");
      chk("pri.ld.lit", cnt, 8'h55);
      chk("pri.ld.ovf", ovf, 1'b0);

      // Invalid BCD load digits become zero
      drive(0, 1, 8'hA7, 0, 1);
      tick("inv.a7");
      chk("inv.a7.lit", cnt, 8'h07);
      drive(0, 1, 8'h3F, 0, 1);
      tick("inv.3f");
      chk("inv.3f.lit", cnt, 8'h30);

      // Enable gating: 20 clks, en every other one
      drive(1, 0, 8'h00, 0, 1);
      tick("gate.clr");
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 8'h00, (i % 2 == 0), 1);
         chk_tc("gate.tc");
         tick("gate");
      end
      chk("gate.lit", cnt, 8'h10);

      // Cascade of two single-digit counters through tc
      drive(0, 0, 8'h00, 0, 1);
      c_clr = 1'b1;
      tick("casc.clr");
      c_clr = 1'b0; c_en = 1'b1;
      for (int i = 0; i < 25; i++) tick("casc");
      c_en = 1'b0;
      chk("casc.val", {hi_cnt, lo_cnt}, 8'h25);

      // Randomized traffic biased toward the wrap points
      for (int i = 0; i < 600; i++) begin
         logic [7:0] lv;
         case ($urandom_range(0, 4))
            0: lv = 8'h98;
            1: lv = 8'h99;
            2: lv = 8'h00;
            3: lv = 8'h01;
            default: lv = 8'($urandom);
         endcase
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), lv,
               ($urandom_range(0, 3) != 0), 1'($urandom));
         chk_tc("rnd.tc");
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/counter_bcd_chain.md
# counter_bcd_chain

Parametrised multi-digit BCD counter, the successor to the single-digit 0-9 counter. It chains DIGITS decade stages, each 0-9, with up/down counting, synchronous clear and parallel load. A combinational terminal-count output lets blocks cascade, and a sticky overflow flag records wrap events. It sits wherever the design needs decimal event counts, timers or display values.

## Interface
- DIGITS, 2, number of BCD decades (1..8); count range 0 .. 10^DIGITS-1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; one step per clk when high
- up_dn  input  1  1 = count up, 0 = count down
- clr  input  1  synchronous clear to zero
- load  input  1  synchronous parallel load
- load_val  input  4*DIGITS  BCD load value; digit i at bits [4i+3:4i]
- cnt  output  4*DIGITS  current count, BCD; digit 0 is least significant
- tc  output  1  terminal count / cascade carry (combinational)
- ovf  output  1  sticky wrap flag

## Operation
- Per-cycle priority, highest first: clr, then load, then en, then hold.
- clr: cnt <= 0 and ovf <= 0.
- load: each digit <= load_val digit. A loaded digit greater than 9 becomes 0; other digits are unaffected. ovf <= 0.
- Count up (en=1, up_dn=1):
  - Digit 0 increments.
  - Digit i (i>0) increments only when all lower digits equal 9.
  - A digit at 9 that increments goes to 0.
- Count down (en=1, up_dn=0):
  - Digit 0 decrements.
  - Digit i (i>0) decrements only when all lower digits equal 0.
  - A digit at 0 that decrements goes to 9.
- Wrap points:
  - Up wrap: all 9s -> all 0s, and ovf <= 1.
  - Down wrap: all 0s -> all 9s, and ovf <= 1.
- ovf stays at 1 until clr, load or reset.
- tc = en & (up_dn ? all digits == 9 : all digits == 0).
  - tc is purely combinational, with no register.
  - It feeds the en of the next counter in a cascade.
- The count only ever holds valid BCD digits (0-9) per digit, whatever the input sequence.

## Timing
- Reset (rst low, asynchronous, any time): cnt = 0 and ovf = 0 immediately. tc follows from cnt and the inputs.
- Reset deassertion takes effect at the next rising clk. The first count happens on the first rising clk with rst high and en high.
- Latency: one clk from clr, load or en to the updated cnt. ovf updates on the same edge as the wrapping count.
- up_dn may change on any cycle. It is sampled on the same edge as en.
- If clr and load are both high, clr wins. If load and en are both high, load wins and no count step is applied.
- When en=0 with no clr or load, cnt and ovf hold.

## Configuration
- Macro: COUNTER_BCD_SATURATE_EN.
- Undefined (default): counting wraps as described above, and wrap sets ovf.
- Defined:
  - Counting saturates. In up mode, all 9s holds at all 9s; in down mode, all 0s holds at all 0s.
  - The saturated step attempt sets ovf (sticky).
  - tc behaviour is unchanged.

## Test plan
- Reset and count (DIGITS=2):
  - rst low, then high; en=1, up_dn=1 for 12 clks -> cnt = 0x12, ovf=0.
  - Assert rst low mid-count -> cnt = 0x00 immediately, without a clk edge.
- Up wrap: load 0x98, en=1, up_dn=1.
  - After 1 clk -> cnt=0x99, tc=1.
  - Next clk -> cnt=0x00, ovf=1, tc=0.
  - With COUNTER_BCD_SATURATE_EN -> cnt stays 0x99 and ovf=1.
- Down wrap: load 0x01, en=1, up_dn=0.
  - Clk -> cnt=0x00, tc=1.
  - Clk -> cnt=0x99, ovf=1.
  - Continue for 10 clks -> cnt=0x89.
- Priority: clr=1, load=1, load_val=0x55, en=1 -> cnt=0x00.
  - Next cycle: clr=0, load=1, en=1 -> cnt=0x55 with no count step.
  - ovf is cleared in both cycles.
- Invalid load: load_val=0xA7 -> cnt=0x07. load_val=0x3F -> cnt=0x30.
- Enable gating and cascade:
  - Toggle en every other cycle for 20 clks from 0x00 up -> cnt=0x10.
  - Chain two DIGITS=1 instances through tc -> en; after 25 enabled clks -> combined {hi,lo} = 2,5.
